inresc_frame_sched: RTL and testbench

- Controller that sequences one Inception_Resnet_C core per frame: loads its 9 kernel registers from a word stream, then feeds T=D*D float32 pixels, then collects T results.
- Sits between the upstream feature-map buffer (ready/valid) and the core's raw clk/reset/valid_in/pxl_in/valid_out/pxl_out interface.
- Owns the core reset pulse, pixel gating, output counting and frame-done signalling.

---
 rtl/inresc_frame_sched_pkg.sv | 28 ++
 rtl/inresc_frame_sched_kernel_regfile.sv | 35 +++
 rtl/inresc_frame_sched.sv | 162 ++++++++++++++++
 tb/tb_inresc_frame_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inresc_frame_sched_pkg.sv
// Shared definitions for the Inception_Resnet_C frame scheduler: FSM state
// encoding, kernel register indices and an FP32 constant used to load kernels.
package inresc_frame_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_LOAD_W = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } sched_state_t;

  // Kernel word order as delivered on the weight stream.
  localparam int K_X0    = 0;
  localparam int K_X1    = 1;
  localparam int K_X2_00 = 2;
  localparam int K_X2_01 = 3;
  localparam int K_X2_02 = 4;
  localparam int K_X3_00 = 5;
  localparam int K_X3_01 = 6;
  localparam int K_X3_02 = 7;
  localparam int K_X5    = 8;

  // 0.01 in IEEE-754 single precision.
  localparam logic [31:0] FP32_0P01 = 32'h3c23d70a;

endpackage

// File: rtl/inresc_frame_sched_kernel_regfile.sv
// Write-indexed kernel register file. Each write lands on the next clock edge;
// all words are exposed flattened on kern_bus, word k at [k*data_width +: data_width].
module inresc_kernel_regfile
  import inresc_frame_sched_pkg::*;
#(
  parameter int data_width = 32,
  parameter int N_KERNEL   = 9,
  parameter int IDX_W      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [IDX_W-1:0]               widx,
  input  logic [data_width-1:0]          wdata,
  output logic [N_KERNEL*data_width-1:0] kern_bus
);

  logic [data_width-1:0] regs [N_KERNEL];

  // Store the incoming word at the addressed slot; reset clears every kernel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_KERNEL; k++) regs[k] <= '0;
    end else if (we) begin
      for (int k = 0; k < N_KERNEL; k++) begin
        if (widx == IDX_W'(k)) regs[k] <= wdata;
      end
    end
  end

  for (genvar g = 0; g < N_KERNEL; g++) begin : g_flat
    assign kern_bus[g*data_width +: data_width] = regs[g];
  end

endmodule

// File: rtl/inresc_frame_sched.sv
// Frame scheduler for one Inception_Resnet_C core: pulses the core reset,
// optionally reloads the nine kernel words, gates T = D*D pixels into the core
// and counts T results back before signalling done.
// Optional drain watchdog: define INRESC_SCHED_WATCHDOG_EN to enable it.
module inresc_frame_sched
  import inresc_frame_sched_pkg::*;
#(
  parameter int data_width = 32,
  parameter int D          = 8,
  parameter int N_KERNEL   = 9,
  parameter int DRAIN_MAX  = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           keep_w,
  input  logic                           w_valid,
  input  logic [data_width-1:0]          w_data,
  output logic                           w_ready,
  input  logic                           px_valid,
  input  logic [data_width-1:0]          px_data,
  output logic                           px_ready,
  output logic [N_KERNEL*data_width-1:0] kern_bus,
  output logic                           core_reset,
  output logic                           core_valid_in,
  output logic [data_width-1:0]          core_pxl_in,
  input  logic                           core_valid_out,
  input  logic [data_width-1:0]          core_pxl_out,
  output logic                           out_valid,
  output logic [data_width-1:0]          out_data,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int T    = D * D;
  localparam int CW   = $clog2(T + 1);
  localparam int WW   = $clog2(N_KERNEL + 1);
  localparam logic [CW-1:0] T_LAST = CW'(T - 1);
  localparam logic [CW-1:0] T_FULL = CW'(T);
  localparam logic [WW-1:0] W_LAST = WW'(N_KERNEL - 1);

  if (DRAIN_MAX < 2) begin : g_drain_max_check
    $error("DRAIN_MAX must be at least 2");
  end

  sched_state_t  state;
  logic          keep;
  logic [WW-1:0] w_cnt;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic          w_hs;
  logic          px_hs;

  // Handshake readiness is a pure decode of registered state and counters.
  assign w_ready  = (state == S_LOAD_W);
  assign px_ready = (state == S_STREAM) && (in_cnt < T_FULL);
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign w_hs     = w_valid && w_ready;
  assign px_hs    = px_valid && px_ready;

  inresc_kernel_regfile #(
    .data_width (data_width),
    .N_KERNEL   (N_KERNEL),
    .IDX_W      (WW)
  ) u_kernel_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (w_hs),
    .widx     (w_cnt),
    .wdata    (w_data),
    .kern_bus (kern_bus)
  );

`ifdef INRESC_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(DRAIN_MAX);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DRAIN_MAX - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign err = 1'b0;
`endif

  // Frame sequencing FSM with registered core-side and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      keep          <= 1'b0;
      w_cnt         <= '0;
      in_cnt        <= '0;
      out_cnt       <= '0;
      core_reset    <= 1'b0;
      core_valid_in <= 1'b0;
      core_pxl_in   <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
`ifdef INRESC_SCHED_WATCHDOG_EN
      wd_cnt        <= '0;
      err           <= 1'b0;
`endif
    end else begin
      core_reset    <= 1'b0;
      core_valid_in <= 1'b0;
      out_valid     <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_CLR;
            keep       <= keep_w;
            core_reset <= 1'b1;
            w_cnt      <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
`ifdef INRESC_SCHED_WATCHDOG_EN
            wd_cnt     <= '0;
            err        <= 1'b0;
`endif
          end
        end
        S_CLR: begin
          state <= keep ? S_STREAM : S_LOAD_W;
        end
        S_LOAD_W: begin
          if (w_hs) begin
            w_cnt <= w_cnt + 1'b1;
            if (w_cnt == W_LAST) state <= S_STREAM;
          end
        end
        S_STREAM, S_DRAIN: begin
          if (px_hs) begin
            core_valid_in <= 1'b1;
            core_pxl_in   <= px_data;
            in_cnt        <= in_cnt + 1'b1;
            if (in_cnt == T_LAST) state <= S_DRAIN;
          end
`ifdef INRESC_SCHED_WATCHDOG_EN
          // A silent core during drain eventually forces the frame closed.
          if (state == S_DRAIN) begin
            if (core_valid_out) begin
              wd_cnt <= '0;
            end else if (wd_cnt == WD_LAST) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
`endif
          // The final result takes priority over any pixel-side transition.
          out_valid <= core_valid_out;
          if (core_valid_out) begin
            out_data <= core_pxl_out;
            out_cnt  <= out_cnt + 1'b1;
            if (out_cnt == T_LAST) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inresc_frame_sched.sv
// Scoreboard bench for inresc_frame_sched: pixels and core results are queued
// when driven and popped when the scheduler presents them.
module tb_inresc_frame_sched;
  import inresc_frame_sched_pkg::*;

  localparam int DW = 32;
  localparam int D  = 8;
  localparam int NK = 9;
  localparam int T  = D * D;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          keep_w = 1'b0;
  logic          w_valid = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          w_ready;
  logic          px_valid = 1'b0;
  logic [DW-1:0] px_data = '0;
  logic          px_ready;
  logic [NK*DW-1:0] kern_bus;
  logic          core_reset;
  logic          core_valid_in;
  logic [DW-1:0] core_pxl_in;
  logic          core_valid_out = 1'b0;
  logic [DW-1:0] core_pxl_out = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic          err;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0]    px_q[$];
  logic [DW-1:0]    res_q[$];
  logic [NK*DW-1:0] exp_kern = '0;

  inresc_frame_sched #(
    .data_width (DW),
    .D          (D),
    .N_KERNEL   (NK),
    .DRAIN_MAX  (1024)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .keep_w         (keep_w),
    .w_valid        (w_valid),
    .w_data         (w_data),
    .w_ready        (w_ready),
    .px_valid       (px_valid),
    .px_data        (px_data),
    .px_ready       (px_ready),
    .kern_bus       (kern_bus),
    .core_reset     (core_reset),
    .core_valid_in  (core_valid_in),
    .core_pxl_in    (core_pxl_in),
    .core_valid_out (core_valid_out),
    .core_pxl_out   (core_pxl_out),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, err, w_ready, px_ready, core_reset, core_valid_in, out_valid} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {busy, done, err, w_ready, px_ready, core_reset, core_valid_in, out_valid});
    end
    vectors++;
    if (kern_bus !== '0 || core_pxl_in !== '0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got kern=%h pxl=%h out=%h want all zero", kern_bus, core_pxl_in, out_data);
    end
    reset = 1'b0;
    core_valid_out = 1'b1;
    core_pxl_out = 32'hdeadbeef;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ignore_out: got vld=%b data=%h busy=%b want 0 0 0", out_valid, out_data, busy);
    end
    core_valid_out = 1'b0;
  endtask

  task automatic test_load(input bit distinct);
    start = 1'b1;
    keep_w = 1'b0;
    tick();
    vectors++;
    if (core_reset !== 1'b1 || busy !== 1'b1 || w_ready !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL load_clr: got rst=%b busy=%b wr=%b err=%b want 1 1 0 0", core_reset, busy, w_ready, err);
    end
    start = 1'b0;
    tick();
    vectors++;
    if (core_reset !== 1'b0 || w_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_enter: got rst=%b wr=%b want 0 1", core_reset, w_ready);
    end
    for (int k = 0; k < NK; k++) begin
      if (distinct && k == 4) begin
        w_valid = 1'b0;
        tick();
        vectors++;
        if (w_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL load_gap: got w_ready=%b want 1", w_ready);
        end
      end
      w_valid = 1'b1;
      w_data = distinct ? (FP32_0P01 + DW'(k * 17 + 1)) : FP32_0P01;
      exp_kern[k*DW +: DW] = w_data;
      tick();
    end
    w_valid = 1'b0;
    vectors++;
    if (w_ready !== 1'b0 || px_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_exit: got wr=%b pr=%b want 0 1", w_ready, px_ready);
    end
    vectors++;
    if (kern_bus !== exp_kern) begin
      miscompares++;
      $display("FAIL load_kern: got %h want %h", kern_bus, exp_kern);
    end
  endtask

  task automatic test_stream(input bit toggle, input int n_px);
    int seen = 0;
    logic hs;
    logic [DW-1:0] exp;
    for (int cyc = 0; cyc < 400 && seen < n_px; cyc++) begin
      px_valid = toggle ? cyc[0] : 1'b1;
      px_data = $urandom;
      hs = px_valid && px_ready;
      if (hs) px_q.push_back(px_data);
      tick();
      vectors++;
      if (hs) begin
        exp = px_q.pop_front();
        seen++;
        if (core_valid_in !== 1'b1 || core_pxl_in !== exp) begin
          miscompares++;
          $display("FAIL stream_px%0d: got vld=%b pxl=%h want 1 %h", seen, core_valid_in, core_pxl_in, exp);
        end
      end else if (core_valid_in !== 1'b0) begin
        miscompares++;
        $display("FAIL stream_idle: got core_valid_in=%b want 0", core_valid_in);
      end
    end
    px_valid = 1'b0;
    vectors++;
    if (seen != n_px) begin
      miscompares++;
      $display("FAIL stream_count: got %0d want %0d", seen, n_px);
    end
    if (n_px == T) begin
      vectors++;
      if (px_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL stream_end: got pr=%b busy=%b done=%b want 0 1 0", px_ready, busy, done);
      end
    end
  endtask

  task automatic test_results(input bit gappy);
    int sent = 0;
    int got = 0;
    logic cv;
    logic [DW-1:0] exp;
    for (int cyc = 0; cyc < 400 && got < T; cyc++) begin
      cv = (sent < T) && (!gappy || ($urandom_range(0, 2) != 0));
      core_valid_out = cv;
      core_pxl_out = $urandom;
      if (cv) begin
        res_q.push_back(core_pxl_out);
        sent++;
      end
      tick();
      vectors++;
      if (cv) begin
        exp = res_q.pop_front();
        got++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
          miscompares++;
          $display("FAIL result%0d: got vld=%b data=%h want 1 %h", got, out_valid, out_data, exp);
        end
      end else if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL result_idle: got out_valid=%b want 0", out_valid);
      end
      if (got < T && (done !== 1'b0 || busy !== 1'b1)) begin
        miscompares++;
        $display("FAIL result_early_done: got done=%b busy=%b want 0 1", done, busy);
      end
    end
    vectors++;
    if (got != T) begin
      miscompares++;
      $display("FAIL result_count: got %0d want %0d", got, T);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_done: got done=%b busy=%b err=%b want 1 0 0", done, busy, err);
    end
    core_valid_out = 1'b1;
    tick();
    core_valid_out = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_ignore_out: got vld=%b done=%b want 0 1", out_valid, done);
    end
  endtask

  task automatic test_keep();
    start = 1'b1;
    keep_w = 1'b1;
    tick();
    vectors++;
    if (core_reset !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL keep_clr: got rst=%b done=%b want 1 0", core_reset, done);
    end
    start = 1'b0;
    keep_w = 1'b0;
    tick();
    vectors++;
    if (core_reset !== 1'b0 || w_ready !== 1'b0 || px_ready !== 1'b1 || kern_bus !== exp_kern) begin
      miscompares++;
      $display("FAIL keep_stream: got rst=%b wr=%b pr=%b kern=%h want 0 0 1 %h",
               core_reset, w_ready, px_ready, kern_bus, exp_kern);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (core_reset !== 1'b0 || busy !== 1'b1 || px_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_start: got rst=%b busy=%b pr=%b want 0 1 1", core_reset, busy, px_ready);
    end
    test_stream(1'b1, T);
    test_results(1'b1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    keep_w = 1'b1;
    tick();
    start = 1'b0;
    keep_w = 1'b0;
    tick();
    test_stream(1'b0, 30);
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, err, w_ready, px_ready, core_reset, core_valid_in, out_valid} !== 8'b0) begin
      miscompares++;
      $display("FAIL midreset_ctrl: got %b want 00000000",
               {busy, done, err, w_ready, px_ready, core_reset, core_valid_in, out_valid});
    end
    vectors++;
    if (kern_bus !== '0 || core_pxl_in !== '0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL midreset_data: got kern=%h pxl=%h out=%h want all zero", kern_bus, core_pxl_in, out_data);
    end
    exp_kern = '0;
    px_q.delete();
    res_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    test_load(1'b1);
    test_stream(1'b0, T);
    test_results(1'b1);
  endtask

`ifdef INRESC_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    start = 1'b1;
    keep_w = 1'b1;
    tick();
    start = 1'b0;
    keep_w = 1'b0;
    tick();
    test_stream(1'b0, T);
    repeat (1023) tick();
    vectors++;
    if (done !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_early: got done=%b err=%b want 0 0", done, err);
    end
    tick();
    vectors++;
    if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_trip: got done=%b err=%b busy=%b want 1 1 0", done, err, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (err !== 1'b0 || core_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_clear: got err=%b rst=%b want 0 1", err, core_reset);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load(1'b0);
    test_stream(1'b0, T);
    test_results(1'b0);
    test_keep();
    test_reset_mid();
`ifdef INRESC_SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
